// File: rtl/version_pkg.sv
// version_pkg: build-identification constants and the helpers used to stream them.
//   - Raw version/timestamp constants. The timestamp fields are BCD so they read
//     directly as decimal in a hex dump.
//   - version_info_t / C_VERSION_INFO: the same constants gathered into one struct.
//   - Frame constants and vstream_byte(), which picks frame byte idx.
package version_pkg;

   localparam logic [7:0]  C_VER_MAJOR    = 8'd0;
   localparam logic [7:0]  C_VER_MINOR    = 8'd0;
   localparam logic [7:0]  C_VER_PATCH    = 8'd0;
   localparam logic [7:0]  C_VER_BUILD    = 8'd76;
   localparam logic [15:0] C_BUILD_YEAR   = 16'h2026;
   localparam logic [7:0]  C_BUILD_MONTH  = 8'h01;
   localparam logic [7:0]  C_BUILD_DAY    = 8'h14;
   localparam logic [7:0]  C_BUILD_HOUR   = 8'h11;
   localparam logic [7:0]  C_BUILD_MINUTE = 8'h20;
   localparam logic [7:0]  C_BUILD_SECOND = 8'h43;

   typedef struct packed {
      logic [7:0]  major;
      logic [7:0]  minor;
      logic [7:0]  patch;
      logic [7:0]  build;
      logic [15:0] year;
      logic [7:0]  month;
      logic [7:0]  day;
      logic [7:0]  hour;
      logic [7:0]  minute;
      logic [7:0]  second;
   } version_info_t;

   localparam version_info_t C_VERSION_INFO = '{
      major:  C_VER_MAJOR,
      minor:  C_VER_MINOR,
      patch:  C_VER_PATCH,
      build:  C_VER_BUILD,
      year:   C_BUILD_YEAR,
      month:  C_BUILD_MONTH,
      day:    C_BUILD_DAY,
      hour:   C_BUILD_HOUR,
      minute: C_BUILD_MINUTE,
      second: C_BUILD_SECOND
   };

   localparam logic [7:0] C_VSTREAM_SYNC0 = 8'hA5;
   localparam logic [7:0] C_VSTREAM_SYNC1 = 8'h56;
   localparam int         C_VSTREAM_LEN   = 16;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } vstream_state_t;

   // Frame byte at position idx. For the checksum slot, sum must be the
   // wrapped sum of bytes 0..14; the result is its two's complement.
   function automatic logic [7:0] vstream_byte(input version_info_t info,
                                               input logic [3:0]    idx,
                                               input logic [7:0]    sum);
      logic [7:0] b;
      b = 8'h00;
      case (idx)
         4'd0:    b = C_VSTREAM_SYNC0;
         4'd1:    b = C_VSTREAM_SYNC1;
         4'd2:    b = info.major;
         4'd3:    b = info.minor;
         4'd4:    b = info.patch;
         4'd5:    b = info.build;
         4'd6:    b = info.year[15:8];
         4'd7:    b = info.year[7:0];
         4'd8:    b = info.month;
         4'd9:    b = info.day;
         4'd10:   b = info.hour;
         4'd11:   b = info.minute;
         4'd12:   b = info.second;
         4'd15:   b = 8'h00 - sum;
         default: b = 8'h00;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/version_streamer_interval_tick.sv
// interval_tick: free-running period counter.
//   clk, rst : clock, asynchronous active-high reset
//   en       : count enable; low clears the count to 0
//   tick     : one-cycle pulse on the last count of each period (PERIOD-1)
module interval_tick #(
   parameter int unsigned PERIOD = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic tick
);

   localparam int unsigned W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam logic [W-1:0] LAST = W'(PERIOD - 1);

   logic [W-1:0] count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (!en) begin
         count <= '0;
      end else if (count == LAST) begin
         count <= '0;
      end else begin
         count <= count + 1'b1;
      end
   end

   assign tick = en && (count == LAST);

endmodule

// File: rtl/version_streamer.sv
// version_streamer: sends the build-identification frame (sync, version,
// timestamp, checksum; 16 bytes) on a byte-wide valid/ready stream.
//   clk, rst     : clock, asynchronous active-high reset
//   start_i      : one-cycle request for a frame
//   auto_en_i    : level enable for periodic frames every AUTO_PERIOD cycles
//   m_data_o     : frame byte
//   m_valid_o    : m_data_o valid
//   m_last_o     : marks the checksum byte (index 15)
//   m_ready_i    : sink ready
//   busy_o       : frame in progress
//   frame_done_o : one-cycle pulse after the checksum byte is accepted
// VERSION_INFO defaults to the package constants; it exists so a different
// identity can be substituted at instantiation.
module version_streamer
   import version_pkg::*;
#(
   parameter int unsigned   AUTO_PERIOD  = 100_000_000,
   parameter version_info_t VERSION_INFO = C_VERSION_INFO
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start_i,
   input  logic       auto_en_i,
   output logic [7:0] m_data_o,
   output logic       m_valid_o,
   output logic       m_last_o,
   input  logic       m_ready_i,
   output logic       busy_o,
   output logic       frame_done_o
);

   localparam logic [3:0] LAST_IDX = 4'(C_VSTREAM_LEN - 1);

   vstream_state_t state, state_next;
   logic           pending, pending_next;
   logic [3:0]     idx, idx_next;
   logic [7:0]     sum, sum_next;
   logic [7:0]     data_next;
   logic           valid_next, last_next, done_next;
   logic           launch, handshake, tick;

   generate
      if (AUTO_PERIOD != 0) begin : g_timer
         interval_tick #(.PERIOD(AUTO_PERIOD)) u_interval_tick (
            .clk  (clk),
            .rst  (rst),
            .en   (auto_en_i),
            .tick (tick)
         );
      end else begin : g_no_timer
         assign tick = 1'b0;
      end
   endgenerate

   assign handshake = m_valid_o && m_ready_i;
   assign busy_o    = (state == ST_SEND);

   always_comb begin
      state_next = state;
      idx_next   = idx;
      sum_next   = sum;
      data_next  = m_data_o;
      valid_next = m_valid_o;
      last_next  = m_last_o;
      done_next  = 1'b0;
      launch     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (pending) begin
               launch     = 1'b1;
               state_next = ST_SEND;
               idx_next   = 4'd0;
               sum_next   = 8'h00;
               data_next  = vstream_byte(VERSION_INFO, 4'd0, 8'h00);
               valid_next = 1'b1;
               last_next  = 1'b0;
            end
         end
         ST_SEND: begin
            if (handshake) begin
               if (idx == LAST_IDX) begin
                  state_next = ST_IDLE;
                  valid_next = 1'b0;
                  last_next  = 1'b0;
                  done_next  = 1'b1;
               end else begin
                  // The next byte is looked up with the updated sum so the
                  // checksum slot sees bytes 0..14 inclusive.
                  idx_next  = idx + 4'd1;
                  sum_next  = sum + m_data_o;
                  data_next = vstream_byte(VERSION_INFO, idx + 4'd1, sum + m_data_o);
                  last_next = ((idx + 4'd1) == LAST_IDX);
               end
            end
         end
         default: state_next = ST_IDLE;
      endcase
      // A request landing on the launch cycle is kept, so it yields a follow-up frame.
      pending_next = start_i | tick | (pending & ~launch);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ST_IDLE;
         pending      <= 1'b0;
         idx          <= 4'd0;
         sum          <= 8'h00;
         m_data_o     <= 8'h00;
         m_valid_o    <= 1'b0;
         m_last_o     <= 1'b0;
         frame_done_o <= 1'b0;
      end else begin
         state        <= state_next;
         pending      <= pending_next;
         idx          <= idx_next;
         sum          <= sum_next;
         m_data_o     <= data_next;
         m_valid_o    <= valid_next;
         m_last_o     <= last_next;
         frame_done_o <= done_next;
      end
   end

endmodule

// File: tb/tb_version_streamer.sv
// tb_version_streamer: directed bench for version_streamer. Two instances: the
// default identity with a 64-cycle auto period, and an all-0xFF identity with
// the timer removed.
module tb_version_streamer;
   import version_pkg::*;

   localparam version_info_t FF_INFO = '1;

   typedef struct {
      int         idx;
      logic [7:0] data;
      logic       last;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0, start_ff = 1'b0, auto_en = 1'b0, rdy = 1'b1;
   logic [7:0] d_data, f_data;
   logic       d_valid, d_last, d_busy, d_done;
   logic       f_valid, f_last, f_busy, f_done;
   logic       sel = 1'b0;
   logic [7:0] mon_data;
   logic       mon_valid, mon_last, mon_busy, mon_done;
   int         cyc = 0;

   version_streamer #(.AUTO_PERIOD(64)) dut (
      .clk(clk), .rst(rst), .start_i(start), .auto_en_i(auto_en),
      .m_data_o(d_data), .m_valid_o(d_valid), .m_last_o(d_last), .m_ready_i(rdy),
      .busy_o(d_busy), .frame_done_o(d_done)
   );

   version_streamer #(.AUTO_PERIOD(0), .VERSION_INFO(FF_INFO)) dut_ff (
      .clk(clk), .rst(rst), .start_i(start_ff), .auto_en_i(auto_en),
      .m_data_o(f_data), .m_valid_o(f_valid), .m_last_o(f_last), .m_ready_i(rdy),
      .busy_o(f_busy), .frame_done_o(f_done)
   );

   assign mon_data  = sel ? f_data  : d_data;
   assign mon_valid = sel ? f_valid : d_valid;
   assign mon_last  = sel ? f_last  : d_last;
   assign mon_busy  = sel ? f_busy  : d_busy;
   assign mon_done  = sel ? f_done  : d_done;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   vec_t        def_tab[16];
   vec_t        ff_tab[16];
   logic [7:0]  r_got[16];
   int          r_n, r_first, r_last, r_done;
   int          r_err_last, r_err_stab, r_err_busy;
   logic [31:0] rpat = 32'hB38E_51D6;

   // Receive one frame from the selected instance. stall: ready follows a fixed
   // bit pattern. inject: pulse start on bytes 3, 6, 9 and on the last handshake.
   task automatic recv(input bit stall, input bit inject, input int budget);
      logic [7:0] held_d;
      logic       held_l;
      bit         holding;
      holding = 0;
      held_d = 8'h00;
      held_l = 1'b0;
      r_n = 0; r_first = -1; r_last = -1; r_done = -1;
      r_err_last = 0; r_err_stab = 0; r_err_busy = 0;
      for (int c = 0; c < budget; c++) begin
         @(negedge clk);
         start    = 1'b0;
         start_ff = 1'b0;
         if (mon_busy !== mon_valid) r_err_busy++;
         if (mon_done === 1'b1) begin
            r_done = cyc;
            if (mon_valid !== 1'b0) r_err_busy++;
            break;
         end
         if (holding && (mon_valid !== 1'b1 || mon_data !== held_d || mon_last !== held_l))
            r_err_stab++;
         if (stall) begin
            rdy  = rpat[0];
            rpat = {rpat[0], rpat[31:1]};
         end else begin
            rdy = 1'b1;
         end
         if (mon_valid === 1'b1) begin
            if (r_first < 0) r_first = cyc;
            if (inject && (r_n == 3 || r_n == 6 || r_n == 9 || r_n == 15)) start = 1'b1;
            if (rdy) begin
               if (r_n < 16) r_got[r_n] = mon_data;
               if (mon_last !== (r_n == 15)) r_err_last++;
               if (mon_last === 1'b1) r_last = cyc;
               r_n++;
               holding = 0;
            end else begin
               holding = 1;
               held_d  = mon_data;
               held_l  = mon_last;
            end
         end
      end
      rdy = 1'b1;
   endtask

   task automatic check_frame(input string name, input bit ff);
      logic [7:0] s;
      s = 8'h00;
      check({name, "_count"}, r_n, 16);
      check({name, "_last"}, r_err_last, 0);
      check({name, "_busy"}, r_err_busy, 0);
      for (int i = 0; i < 16; i++) begin
         check($sformatf("%s_byte%0d", name, i), r_got[i], ff ? ff_tab[i].data : def_tab[i].data);
         s = s + r_got[i];
      end
      check({name, "_sum_zero"}, s, 8'h00);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] def_bytes[16];
      logic [7:0] ff_bytes[16];
      int t_start, t1, t_last1, acc, bad_v, bad_d;
      def_bytes = '{8'hA5, 8'h56, 8'h00, 8'h00, 8'h00, 8'h4C, 8'h20, 8'h26,
                    8'h01, 8'h14, 8'h11, 8'h20, 8'h43, 8'h00, 8'h00, 8'hEA};
      ff_bytes  = '{8'hA5, 8'h56, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                    8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h10};
      for (int i = 0; i < 16; i++) begin
         def_tab[i] = '{i, def_bytes[i], (i == 15)};
         ff_tab[i]  = '{i, ff_bytes[i], (i == 15)};
      end

      // reset state
      repeat (3) @(negedge clk);
      check("rst_valid", d_valid, 1'b0);
      check("rst_last",  d_last,  1'b0);
      check("rst_data",  d_data,  8'h00);
      check("rst_busy",  d_busy,  1'b0);
      check("rst_done",  d_done,  1'b0);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("idle_valid", d_valid, 1'b0);

      // single frame, ready high
      @(negedge clk);
      start = 1'b1;
      t_start = cyc;
      recv(0, 0, 60);
      check_frame("t1", 0);
      check("t1_first_cycle", r_first - t_start, 2);
      check("t1_last_cycle",  r_last - t_start, 17);
      check("t1_done_cycle",  r_done - t_start, 18);

      // same frame with ready stalls
      @(negedge clk);
      start = 1'b1;
      recv(1, 0, 400);
      check_frame("t2", 0);
      check("t2_stable", r_err_stab, 0);

      // requests during a frame collapse into one follow-up frame
      @(negedge clk);
      start = 1'b1;
      recv(0, 1, 60);
      check_frame("t3a", 0);
      t_last1 = r_last;
      recv(0, 0, 60);
      check_frame("t3b", 0);
      check("t3_gap", r_first - t_last1, 2);
      recv(0, 0, 30);
      check("t3_no_third", r_first, -1);

      // reset at byte 7
      @(negedge clk);
      start = 1'b1;
      acc = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (d_valid && acc == 7) break;
         if (d_valid) acc++;
      end
      check("t4_byte7", d_data, 8'h26);
      rst = 1'b1;
      #1;
      check("t4_rst_valid", d_valid, 1'b0);
      check("t4_rst_busy",  d_busy,  1'b0);
      check("t4_rst_done",  d_done,  1'b0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      bad_v = 0;
      bad_d = 0;
      repeat (20) begin
         @(negedge clk);
         if (d_valid !== 1'b0) bad_v++;
         if (d_done !== 1'b0) bad_d++;
      end
      check("t4_idle_valid", bad_v, 0);
      check("t4_no_done", bad_d, 0);
      @(negedge clk);
      start = 1'b1;
      recv(0, 0, 60);
      check_frame("t4", 0);

      // periodic frames, AUTO_PERIOD = 64
      @(negedge clk);
      auto_en = 1'b1;
      t_start = cyc;
      recv(0, 0, 100);
      check("t5_first", r_first - t_start, 65);
      check("t5_cksum", r_got[15], 8'hEA);
      t1 = r_first;
      recv(0, 0, 100);
      check("t5_period", r_first - t1, 64);
      @(negedge clk);
      auto_en = 1'b0;
      repeat (10) @(negedge clk);
      auto_en = 1'b1;
      t_start = cyc;
      recv(0, 0, 100);
      check("t5_reenable", r_first - t_start, 65);
      auto_en = 1'b0;

      // all-0xFF identity
      repeat (3) @(negedge clk);
      sel = 1'b1;
      @(negedge clk);
      start_ff = 1'b1;
      recv(0, 0, 60);
      check_frame("t6", 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
